// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int          CNT_W             = 4;

endpackage

// File: rtl/mem_word_array.sv
// Word storage with a synchronous write port and a registered read port.
// The read register doubles as the responder's load-result output.
module mem_word_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic          re,
    input  logic          clr,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Storage carries no reset so it maps onto block RAM and survives a reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= 32'd0;
        end else if (clr) begin
            rdata <= 32'd0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle load/store responder: accepts one request, waits WAIT_STATES
// cycles, commits the access, then pulses ready_o for one cycle.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 256,
    parameter int          WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        addr_error_o
);

    localparam int AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               op_write_reg;
    logic               err_reg;
    logic [AW-1:0]      idx_reg;
    logic [31:0]        wdata_reg;

    logic               req_seen;
    logic               req_write;
    logic               req_err;
    logic [31:0]        word_idx;

    logic               commit;
    logic               commit_write;
    logic               commit_err;
    logic [AW-1:0]      commit_idx;
    logic [31:0]        commit_wdata;

    assign req_seen  = mem_read_i | mem_write_i;
    assign req_write = mem_write_i & ~mem_read_i;
    assign word_idx  = (address_i - BASE_ADDR) >> 2;
    assign req_err   = (mem_read_i & mem_write_i)
                     | (address_i[1:0] != 2'b00)
                     | (address_i < BASE_ADDR)
                     | (word_idx >= 32'(MEMORY_DEPTH));

    assign stall_o = ((state_reg == IDLE) && req_seen) || (state_reg == BUSY);

    // With no wait states the access commits on the acceptance edge straight
    // from the inputs; otherwise it uses the latched copy on the last BUSY edge.
    always_comb begin
        commit       = (state_reg == BUSY) && (cnt_reg == CNT_W'(1));
        commit_write = op_write_reg;
        commit_err   = err_reg;
        commit_idx   = idx_reg;
        commit_wdata = wdata_reg;
        if (WAIT_STATES == 0) begin
            commit       = (state_reg == IDLE) && req_seen;
            commit_write = req_write;
            commit_err   = req_err;
            commit_idx   = word_idx[AW-1:0];
            commit_wdata = write_data_i;
        end
    end

    mem_word_array #(
        .DEPTH (MEMORY_DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (commit & commit_write & ~commit_err),
        .re    (commit & ~commit_write & ~commit_err),
        .clr   (commit & ~commit_write & commit_err),
        .addr  (commit_idx),
        .wdata (commit_wdata),
        .rdata (read_data_o)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_write_reg <= 1'b0;
            err_reg      <= 1'b0;
            idx_reg      <= '0;
            wdata_reg    <= 32'd0;
            ready_o      <= 1'b0;
            addr_error_o <= 1'b0;
        end else begin
            ready_o      <= 1'b0;
            addr_error_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_seen) begin
                        op_write_reg <= req_write;
                        err_reg      <= req_err;
                        idx_reg      <= word_idx[AW-1:0];
                        wdata_reg    <= write_data_i;
                        cnt_reg      <= CNT_W'(WAIT_STATES);
                        if (WAIT_STATES == 0) begin
                            state_reg    <= DONE;
                            ready_o      <= 1'b1;
                            addr_error_o <= req_err;
                        end else begin
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    // Counter reaches zero at this edge: the access commits here.
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg    <= DONE;
                        ready_o      <= 1'b1;
                        addr_error_o <= err_reg;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 and 0 wait states) checked
// against a word-array reference model.
module tb_data_mem_responder;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd    [2];
    logic        wr    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rdata [2];
    logic        rdy   [2];
    logic        stall [2];
    logic        aerr  [2];

    int          ws [2] = '{2, 0};
    logic [31:0] mem_m   [2][DEPTH];
    logic [31:0] last_rd [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) dut_w2 (
        .clk(clk), .reset(reset), .mem_read_i(rd[0]), .mem_write_i(wr[0]),
        .address_i(addr[0]), .write_data_i(wd[0]), .read_data_o(rdata[0]),
        .ready_o(rdy[0]), .stall_o(stall[0]), .addr_error_o(aerr[0]));

    data_mem_responder #(.MEMORY_DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) dut_w0 (
        .clk(clk), .reset(reset), .mem_read_i(rd[1]), .mem_write_i(wr[1]),
        .address_i(addr[1]), .write_data_i(wd[1]), .read_data_o(rdata[1]),
        .ready_o(rdy[1]), .stall_o(stall[1]), .addr_error_o(aerr[1]));

    // Reference model: applies one completed request, returns whether it errs.
    function automatic bit model_apply(int s, bit r, bit w, logic [31:0] a, logic [31:0] d);
        bit e;
        longint unsigned widx;
        widx = (longint'(a) - longint'(BASE)) / 4;
        e = (r && w) || (a < BASE) || (a % 4 != 0) || (widx >= DEPTH);
        if (!e) begin
            if (w) mem_m[s][widx] = d;
            else   last_rd[s] = mem_m[s][widx];
        end else if (!(w && !r)) begin
            last_rd[s] = 32'd0;
        end
        return e;
    endfunction

    // Drives one request, holds it until ready_o, releases it at the DONE edge.
    task automatic do_access(input int s, input bit r, input bit w, input logic [31:0] a,
                             input logic [31:0] d, output int lat, output int stall_cnt,
                             output bit stall_done, output logic [31:0] rv, output bit ev);
        lat = -1; stall_cnt = 0; stall_done = 1'b0; rv = 32'd0; ev = 1'b0;
        @(posedge clk); #1;
        rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy[s] === 1'b1) begin
                lat = c; stall_done = stall[s]; rv = rdata[s]; ev = aerr[s];
                break;
            end
            if (stall[s] === 1'b1) stall_cnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rd[s] = 1'b0; wr[s] = 1'b0;
        checks++;
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout dut=%0d addr=%h: no ready_o within 40 cycles, required one", s, a);
        end
        $display("txn dut=%0d rd=%0b wr=%0b addr=%h wdata=%h lat=%0d stall=%0d rdata=%h err=%0b",
                 s, r, w, a, d, lat, stall_cnt, rv, ev);
    endtask

    task automatic preload(input int s, input int n);
        int lat, sc; bit sd, ev, e; logic [31:0] rv, d;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            do_access(s, 1'b0, 1'b1, BASE + 32'(4 * i), d, lat, sc, sd, rv, ev);
            e = model_apply(s, 1'b0, 1'b1, BASE + 32'(4 * i), d);
            checks++;
            if (ev !== e || lat !== ws[s] + 1) begin
                errors++;
                $display("FAIL preload dut=%0d word=%0d: err=%0b lat=%0d, required err=%0b lat=%0d",
                         s, i, ev, lat, e, ws[s] + 1);
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = 32'd0; wd[s] = 32'd0;
            last_rd[s] = 32'd0;
        end
        #2;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (rdata[s] !== 32'd0 || rdy[s] !== 1'b0 || stall[s] !== 1'b0 || aerr[s] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut=%0d: rdata=%h ready=%b stall=%b err=%b, required all 0",
                         s, rdata[s], rdy[s], stall[s], aerr[s]);
            end
        end
        @(posedge clk); #1; reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                checks++;
                if (stall[s] !== 1'b0 || rdy[s] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle dut=%0d cycle=%0d: stall=%b ready=%b, required 0 0",
                             s, c, stall[s], rdy[s]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat, sc; bit sd, ev, e; logic [31:0] rv;
        logic [31:0] a [3] = '{32'h1001_0008, 32'h1001_0008, 32'h1001_0004};
        bit          w [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] d [3];
        d[0] = 32'hDEAD_BEEF; d[1] = 32'd0; d[2] = $urandom;
        for (int i = 0; i < 3; i++) begin
            do_access(0, !w[i], w[i], a[i], d[i], lat, sc, sd, rv, ev);
            e = model_apply(0, !w[i], w[i], a[i], d[i]);
            checks++;
            if (lat !== 3 || sc !== 3 || sd !== 1'b0 || ev !== e || rv !== last_rd[0]) begin
                errors++;
                $display("FAIL write_read step=%0d: lat=%0d stall_cycles=%0d stall_done=%b err=%b rdata=%h, required 3 3 0 %b %h",
                         i, lat, sc, sd, ev, rv, e, last_rd[0]);
            end
        end
        checks++;
        if (rv !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_hold: rdata=%h after write, required deadbeef", rv);
        end
    endtask

    task automatic test_zero_wait();
        int lat, sc, k; bit sd, ev, e, seen; logic [31:0] rv;
        do_access(1, 1'b1, 1'b0, BASE, 32'd0, lat, sc, sd, rv, ev);
        e = model_apply(1, 1'b1, 1'b0, BASE, 32'd0);
        checks++;
        if (lat !== 1 || sc !== 1 || sd !== 1'b0 || ev !== e || rv !== last_rd[1]) begin
            errors++;
            $display("FAIL zero_wait_load: lat=%0d stall_cycles=%0d stall_done=%b err=%b rdata=%h, required 1 1 0 %b %h",
                     lat, sc, sd, ev, rv, e, last_rd[1]);
        end
        k = 0;
        @(posedge clk); #1;
        rd[1] = 1'b1; addr[1] = BASE;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            seen = rdy[1];
            checks++;
            if (seen !== (c % 2 == 1)) begin
                errors++;
                $display("FAIL back_to_back cycle=%0d: ready=%b, required %b", c, seen, (c % 2 == 1));
            end
            if (seen === 1'b1) begin
                e = model_apply(1, 1'b1, 1'b0, BASE + 32'(4 * k), 32'd0);
                checks++;
                if (rdata[1] !== last_rd[1] || aerr[1] !== e) begin
                    errors++;
                    $display("FAIL back_to_back_data word=%0d: rdata=%h err=%b, required %h %b",
                             k, rdata[1], aerr[1], last_rd[1], e);
                end
                $display("txn dut=1 b2b load word=%0d rdata=%h", k, rdata[1]);
                k++;
            end
            @(posedge clk); #1;
            if (seen === 1'b1) addr[1] = BASE + 32'(4 * k);
        end
        rd[1] = 1'b0;
    endtask

    task automatic test_errors();
        int lat, sc; bit sd, ev, e; logic [31:0] rv;
        bit          r [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          w [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] a [6] = '{32'h1001_0008, 32'h1001_0002, 32'h1001_0400,
                               32'h1001_0000, 32'h1000_FFFC, 32'h1001_0000};
        bit          x [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_access(0, r[i], w[i], a[i], $urandom, lat, sc, sd, rv, ev);
            e = model_apply(0, r[i], w[i], a[i], wd[0]);
            checks++;
            if (ev !== x[i] || ev !== e || lat !== 3 || ((r[i] && w[i]) ? 1'b0 : (rv !== last_rd[0]))) begin
                errors++;
                $display("FAIL error_case=%0d addr=%h: err=%b lat=%0d rdata=%h, required %b 3 %h",
                         i, a[i], ev, lat, rv, x[i], last_rd[0]);
            end
        end
        do_access(0, 1'b1, 1'b0, BASE + 32'd8, 32'd0, lat, sc, sd, rv, ev);
        e = model_apply(0, 1'b1, 1'b0, BASE + 32'd8, 32'd0);
        checks++;
        if (rv !== last_rd[0] || ev !== e) begin
            errors++;
            $display("FAIL error_array_intact: word2=%h, required %h", rv, last_rd[0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat, sc; bit sd, ev, e; logic [31:0] rv;
        do_access(0, 1'b0, 1'b1, 32'h1001_0010, 32'd0, lat, sc, sd, rv, ev);
        e = model_apply(0, 1'b0, 1'b1, 32'h1001_0010, 32'd0);
        do_access(0, 1'b1, 1'b0, 32'h1001_0004, 32'd0, lat, sc, sd, rv, ev);
        e = model_apply(0, 1'b1, 1'b0, 32'h1001_0004, 32'd0);
        @(posedge clk); #1;
        wr[0] = 1'b1; addr[0] = 32'h1001_0010; wd[0] = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 1'b1; wr[0] = 1'b0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;
        #1;
        checks++;
        if (rdata[0] !== 32'd0 || rdy[0] !== 1'b0 || stall[0] !== 1'b0 || aerr[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: rdata=%h ready=%b stall=%b err=%b, required all 0",
                     rdata[0], rdy[0], stall[0], aerr[0]);
        end
        @(posedge clk); #1; reset = 1'b0;
        do_access(0, 1'b1, 1'b0, 32'h1001_0010, 32'd0, lat, sc, sd, rv, ev);
        e = model_apply(0, 1'b1, 1'b0, 32'h1001_0010, 32'd0);
        checks++;
        if (rv !== 32'd0 || ev !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL reset_mid_abandon: rdata=%h err=%b lat=%0d, required 00000000 0 3", rv, ev, lat);
        end
    endtask

    task automatic test_random();
        int lat, sc, s, kind; bit sd, ev, e, r, w; logic [31:0] a, d, rv;
        for (int i = 0; i < 30; i++) begin
            s = $urandom_range(0, 1);
            kind = $urandom_range(0, 15);
            r = $urandom_range(0, 1);
            w = !r;
            a = BASE + 32'(4 * $urandom_range(0, 7));
            if (kind == 0)      a = a + 32'($urandom_range(1, 3));
            else if (kind == 1) a = BASE + 32'(4 * (DEPTH + $urandom_range(0, 15)));
            else if (kind == 2) a = BASE - 32'(4 * $urandom_range(1, 8));
            else if (kind == 3) begin r = 1'b1; w = 1'b1; end
            d = $urandom;
            do_access(s, r, w, a, d, lat, sc, sd, rv, ev);
            e = model_apply(s, r, w, a, d);
            checks++;
            if (lat !== ws[s] + 1 || sc !== ws[s] + 1 || sd !== 1'b0 || ev !== e ||
                ((r && w) ? 1'b0 : (rv !== last_rd[s]))) begin
                errors++;
                $display("FAIL random i=%0d dut=%0d addr=%h: lat=%0d stall_cycles=%0d err=%b rdata=%h, required %0d %0d %b %h",
                         i, s, a, lat, sc, ev, rv, ws[s] + 1, ws[s] + 1, e, last_rd[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        preload(0, 8);
        preload(1, 8);
        test_write_read();
        test_zero_wait();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
